// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, feeds IF/ID InstIn.
// Latency: word on inst_out one cycle after imem_rvalid (or after pause falls if parked in the skid buffer).
// Backpressure: pause freezes outputs and parks a late response; IF_FETCH_CNT_EN adds fetch/stall counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic [31:0] pc_out
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] buf_inst, buf_pc;
  logic        buf_we;
  logic        deliver;
  logic [31:0] dlv_inst, dlv_pc;

  assign imem_req  = rst && (state == S_ISSUE);
  assign imem_addr = pc;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    fpc_n    = fpc;
    buf_we   = 1'b0;
    deliver  = 1'b0;
    dlv_inst = imem_rdata;
    dlv_pc   = fpc;
    case (state)
      S_ISSUE: begin
        // Responses seen here are not ours and are ignored.
        if (redirect) begin
          pc_n = redirect_pc;
          if (imem_gnt) state_n = S_DISCARD;
        end else if (imem_gnt) begin
          fpc_n   = pc;
          pc_n    = pc + 32'd4;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_n = S_ISSUE;
          if (redirect) begin
            pc_n = redirect_pc;
          end else if (!pause) begin
            deliver = 1'b1;
          end else begin
            buf_we  = 1'b1;
            state_n = S_HOLD;
          end
        end else if (redirect) begin
          pc_n    = redirect_pc;
          state_n = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = S_ISSUE;
        end else if (!pause) begin
          deliver  = 1'b1;
          dlv_inst = buf_inst;
          dlv_pc   = buf_pc;
          state_n  = S_ISSUE;
        end
      end
      S_DISCARD: begin
        // Latest redirect wins while the stale response is still in flight.
        if (redirect) pc_n = redirect_pc;
        if (imem_rvalid) state_n = S_ISSUE;
      end
      default: state_n = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_ISSUE;
      pc         <= RESET_PC;
      fpc        <= 32'h0;
      buf_inst   <= 32'h0;
      buf_pc     <= 32'h0;
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
      pc_out     <= 32'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      fpc   <= fpc_n;
      if (buf_we) begin
        buf_inst <= imem_rdata;
        buf_pc   <= fpc;
      end
      // Idle cycles emit a bubble so IF/ID never captures the same word twice.
      if (redirect) begin
        inst_out   <= NOP_INST;
        inst_valid <= 1'b0;
      end else if (!pause) begin
        if (deliver) begin
          inst_out   <= dlv_inst;
          pc_out     <= dlv_pc;
          inst_valid <= 1'b1;
        end else begin
          inst_out   <= NOP_INST;
          inst_valid <= 1'b0;
        end
      end
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (deliver && !redirect) fetch_cnt <= fetch_cnt + 32'd1;
      if (pause && inst_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: memory model + PC-sequence reference, scoreboard of expected deliveries.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, pause, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst_out, pc_out;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pause(pause), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .inst_valid(inst_valid), .pc_out(pc_out)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc = RST_PC;
  int          p_gnt = 100, p_pause = 0, p_redir = 0, p_rst = 0, lat_max = 1;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          deliv = 0, total_deliv = 0, stalls = 0;
  logic [31:0] p_out = 32'h0, p_pc = 32'h0;
  logic        p_v = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus for the next posedge, plus the reference-model update for that edge.
  task automatic step();
    logic        r_n, pz, rd, g, rv;
    logic [31:0] rpc, rdat;
    @(negedge clk);
    #1;
    r_n = !($urandom_range(99) < p_rst);
    pz  = $urandom_range(99) < p_pause;
    rd  = $urandom_range(99) < p_redir;
    case ($urandom_range(3))
      0: rpc = 32'h0000_0100;
      1: rpc = 32'hFFFF_FFFC;
      2: rpc = 32'hFFFF_FFF8;
      default: begin rpc = $urandom; rpc[1:0] = 2'b00; end
    endcase
    g    = r_n && imem_req && !mem_busy && ($urandom_range(99) < p_gnt);
    rv   = 1'b0;
    rdat = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv       = 1'b1;
        rdat     = mem_word(mem_addr);
        mem_busy = 0;
      end
    end else if (imem_req && $urandom_range(99) < 10) begin
      rv = 1'b1;  // stray response while issuing must be ignored
    end
    if (g) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(lat_max, 1);
      mem_addr = imem_addr;
    end
    rst = r_n; pause = pz; redirect = rd; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
    if (!r_n) begin
      sb.delete();
      exp_pc = RST_PC;
    end else if (rd) begin
      sb.delete();
      exp_pc = rpc;
    end else if (g) begin
      check("req_addr", imem_addr, exp_pc);
      sb.push_back('{exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Monitor: inputs still on the pins at negedge are the ones that governed the edge just past.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, inst_valid}, 32'h0);
      check("rst_inst", inst_out, NOP);
      check("rst_pc", pc_out, 32'h0);
      deliv  = 0;
      stalls = 0;
    end else begin
      if (pause && p_v) stalls++;
      if (redirect) begin
        check("redir_valid", {31'h0, inst_valid}, 32'h0);
        check("redir_inst", inst_out, NOP);
      end else if (pause) begin
        check("hold_valid", {31'h0, inst_valid}, {31'h0, p_v});
        check("hold_inst", inst_out, p_out);
        check("hold_pc", pc_out, p_pc);
      end else if (inst_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_delivery: got pc %h inst %h expected none", pc_out, inst_out);
        end else begin
          n_cmp--;
          e = sb.pop_front();
          check("deliv_pc", pc_out, e.pc);
          check("deliv_inst", inst_out, e.dat);
        end
        deliv++;
        total_deliv++;
      end else begin
        check("bubble_inst", inst_out, NOP);
      end
    end
`ifdef IF_FETCH_CNT_EN
    check("fetch_cnt", fetch_cnt, deliv);
    check("stall_cnt", stall_cnt, stalls);
`endif
    p_out = inst_out;
    p_pc  = pc_out;
    p_v   = inst_valid;
  end

  initial begin
    rst = 1'b0; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    p_rst = 100;
    repeat (3) step();

    // Zero-wait memory: one instruction every two cycles, 0x0 then 0x4 first.
    p_rst = 0; p_gnt = 100; p_pause = 0; p_redir = 0; lat_max = 1;
    repeat (12) step();
    check("throughput", deliv, 5);

    // Long pauses with slow memory: responses land in the skid buffer.
    p_pause = 60; lat_max = 3;
    repeat (200) step();

    // Full random mix: redirects, pauses, resets mid-fetch, wrap targets.
    p_gnt = 60; p_pause = 25; p_redir = 8; p_rst = 1;
    repeat (3000) step();

    // Drain: no new requests, let outstanding work finish.
    p_gnt = 0; p_pause = 0; p_redir = 0; p_rst = 0;
    repeat (12) step();
    check("sb_drained", sb.size(), 0);
    n_cmp++;
    if (total_deliv < 100) begin
      n_err++;
      $display("FAIL progress: got %0d deliveries expected at least 100", total_deliv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
